// File: rtl/umi_loc_mem_pkg.sv
// rtl/umi_loc_mem_pkg.sv - shared constants, FSM states and size helpers for umi_loc_mem
package umi_loc_mem_pkg;

    localparam logic [7:0] UMI_ATYPE_ADD  = 8'h00;
    localparam logic [7:0] UMI_ATYPE_AND  = 8'h01;
    localparam logic [7:0] UMI_ATYPE_OR   = 8'h02;
    localparam logic [7:0] UMI_ATYPE_XOR  = 8'h03;
    localparam logic [7:0] UMI_ATYPE_MAX  = 8'h04;
    localparam logic [7:0] UMI_ATYPE_MIN  = 8'h05;
    localparam logic [7:0] UMI_ATYPE_MAXU = 8'h06;
    localparam logic [7:0] UMI_ATYPE_MINU = 8'h07;
    localparam logic [7:0] UMI_ATYPE_SWAP = 8'h08;

    typedef enum logic {
        IDLE,
        WB
    } state_t;

    // Operands never exceed one 64-bit word, so sizes 4..7 collapse to 3.
    function automatic logic [2:0] clamp_size(input logic [2:0] size);
        return (size > 3'd3) ? 3'd3 : size;
    endfunction

    function automatic logic [7:0] byte_mask(input logic [2:0] size);
        case (clamp_size(size))
            3'd0:    return 8'h01;
            3'd1:    return 8'h03;
            3'd2:    return 8'h0f;
            default: return 8'hff;
        endcase
    endfunction

    function automatic logic [63:0] bit_mask(input logic [2:0] size);
        logic [7:0]  bm;
        logic [63:0] m;
        bm = byte_mask(size);
        for (int i = 0; i < 8; i++) begin
            m[8*i +: 8] = {8{bm[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/umi_loc_atomic_alu.sv
// rtl/umi_loc_atomic_alu.sv - combinational UMI atomic ALU on right-aligned operands
module umi_loc_atomic_alu
    import umi_loc_mem_pkg::*;
(
    input  logic [7:0]  atype,
    input  logic [2:0]  size,
    input  logic [63:0] old,
    input  logic [63:0] operand,
    output logic [63:0] result
);

    logic [63:0] mask;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] sa;
    logic [63:0] sb;

    function automatic logic [63:0] sext(input logic [63:0] v, input logic [2:0] sz);
        case (sz)
            3'd0:    return {{56{v[7]}}, v[7:0]};
            3'd1:    return {{48{v[15]}}, v[15:0]};
            3'd2:    return {{32{v[31]}}, v[31:0]};
            default: return v;
        endcase
    endfunction

    assign mask = bit_mask(size);
    assign a    = old & mask;
    assign b    = operand & mask;
    assign sa   = sext(a, clamp_size(size));
    assign sb   = sext(b, clamp_size(size));

    // Unknown opcodes hand back the old value so the write-back is a no-op.
    always_comb begin
        result = a;
        case (atype)
            UMI_ATYPE_ADD:  result = (a + b) & mask;
            UMI_ATYPE_AND:  result = a & b;
            UMI_ATYPE_OR:   result = a | b;
            UMI_ATYPE_XOR:  result = a ^ b;
            UMI_ATYPE_MAX:  result = ($signed(sa) > $signed(sb)) ? a : b;
            UMI_ATYPE_MIN:  result = ($signed(sa) < $signed(sb)) ? a : b;
            UMI_ATYPE_MAXU: result = (a > b) ? a : b;
            UMI_ATYPE_MINU: result = (a < b) ? a : b;
            UMI_ATYPE_SWAP: result = b;
            default:        result = a;
        endcase
    end

endmodule

// File: rtl/umi_loc_mem.sv
// rtl/umi_loc_mem.sv - byte-addressable scratchpad behind umi_endpoint loc_* port
// Atomic read-modify-write support is built only when UMI_LOC_MEM_ATOMIC_EN is defined.
module umi_loc_mem
    import umi_loc_mem_pkg::*;
#(
    parameter int DW    = 256,
    parameter int AW    = 64,
    parameter int DEPTH = 256
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] loc_addr,
    input  logic          loc_write,
    input  logic          loc_read,
    input  logic          loc_atomic,
    input  logic [7:0]    loc_atype,
    input  logic [2:0]    loc_size,
    input  logic [DW-1:0] loc_wrdata,
    output logic [DW-1:0] loc_rddata,
    output logic          loc_ready
);

    localparam int IW = $clog2(DEPTH);

    logic [63:0]   mem [DEPTH];
    logic [IW-1:0] idx;
    logic [2:0]    sz;
    logic [2:0]    lane;
    logic [5:0]    sh;
    logic [63:0]   old_word;
    logic [63:0]   rd_ext;
    logic [63:0]   bmask;
    logic [63:0]   wr_word;
    logic          alive_q;
    logic [63:0]   rd_q;
    logic          mem_we;
    logic [IW-1:0] mem_idx;
    logic [63:0]   mem_wdata;
    logic          unused_bits;

    assign idx      = loc_addr[3 +: IW];
    assign sz       = clamp_size(loc_size);
    assign lane     = loc_addr[2:0] & (3'b111 << sz);
    assign sh       = {lane, 3'b000};
    assign old_word = mem[idx];
    assign rd_ext   = (old_word >> sh) & bit_mask(sz);
    assign bmask    = bit_mask(sz) << sh;
    assign wr_word  = (old_word & ~bmask) | ((loc_wrdata[63:0] << sh) & bmask);

    assign loc_rddata = {{(DW-64){1'b0}}, rd_q};

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_idx] <= mem_wdata;
        end
    end

`ifdef UMI_LOC_MEM_ATOMIC_EN
    state_t        state_q;
    state_t        state_d;
    logic [IW-1:0] a_idx;
    logic [2:0]    a_sz;
    logic [5:0]    a_sh;
    logic [7:0]    a_type;
    logic [63:0]   a_opnd;
    logic [63:0]   a_old_word;
    logic [63:0]   a_mask;
    logic [63:0]   a_old_op;
    logic [63:0]   a_new_op;
    logic [63:0]   a_new_word;

    assign a_mask     = bit_mask(a_sz) << a_sh;
    assign a_old_op   = (a_old_word >> a_sh) & bit_mask(a_sz);
    assign a_new_word = (a_old_word & ~a_mask) | ((a_new_op << a_sh) & a_mask);

    umi_loc_atomic_alu u_alu (
        .atype   (a_type),
        .size    (a_sz),
        .old     (a_old_op),
        .operand (a_opnd),
        .result  (a_new_op)
    );

    always_comb begin
        state_d   = state_q;
        loc_ready = alive_q && !reset && (state_q == IDLE);
        case (state_q)
            IDLE:    if (loc_ready && loc_atomic) state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Reset during WB drops the write-back, leaving the old word in place.
    always_comb begin
        mem_we    = 1'b0;
        mem_idx   = idx;
        mem_wdata = wr_word;
        if (!reset) begin
            if (state_q == WB) begin
                mem_we    = 1'b1;
                mem_idx   = a_idx;
                mem_wdata = a_new_word;
            end else if (loc_ready && !loc_atomic && loc_write) begin
                mem_we    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (loc_ready && loc_atomic) begin
            a_idx      <= idx;
            a_sz       <= sz;
            a_sh       <= sh;
            a_type     <= loc_atype;
            a_opnd     <= loc_wrdata[63:0];
            a_old_word <= old_word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            alive_q <= 1'b0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            alive_q <= 1'b1;
            if (state_q == WB) begin
                rd_q <= a_old_op;
            end else if (loc_ready && !loc_atomic && loc_read) begin
                rd_q <= rd_ext;
            end
        end
    end

    assign unused_bits = ^{loc_addr[AW-1:3+IW], loc_wrdata[DW-1:64]};
`else
    assign loc_ready = alive_q && !reset;

    always_comb begin
        mem_idx   = idx;
        mem_wdata = wr_word;
        mem_we    = loc_ready && !loc_atomic && loc_write;
    end

    // Without atomic support an atomic request degrades to a plain read.
    always_ff @(posedge clk) begin
        if (reset) begin
            alive_q <= 1'b0;
            rd_q    <= '0;
        end else begin
            alive_q <= 1'b1;
            if (loc_ready && (loc_read || loc_atomic)) begin
                rd_q <= rd_ext;
            end
        end
    end

    assign unused_bits = ^{loc_addr[AW-1:3+IW], loc_wrdata[DW-1:64], loc_atype};
`endif

endmodule

// File: tb/tb_umi_loc_mem.sv
// tb/tb_umi_loc_mem.sv - directed table-driven bench for umi_loc_mem (both UMI_LOC_MEM_ATOMIC_EN builds)
module tb_umi_loc_mem;

    localparam int DW = 256;
    localparam int AW = 64;
`ifdef UMI_LOC_MEM_ATOMIC_EN
    localparam bit ATOMIC_EN = 1'b1;
`else
    localparam bit ATOMIC_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] loc_addr;
    logic          loc_write;
    logic          loc_read;
    logic          loc_atomic;
    logic [7:0]    loc_atype;
    logic [2:0]    loc_size;
    logic [DW-1:0] loc_wrdata;
    logic [DW-1:0] loc_rddata;
    logic          loc_ready;

    int n_tests = 0;
    int n_fail  = 0;

    umi_loc_mem #(.DW(DW), .AW(AW), .DEPTH(256)) dut (
        .clk        (clk),
        .reset      (reset),
        .loc_addr   (loc_addr),
        .loc_write  (loc_write),
        .loc_read   (loc_read),
        .loc_atomic (loc_atomic),
        .loc_atype  (loc_atype),
        .loc_size   (loc_size),
        .loc_wrdata (loc_wrdata),
        .loc_rddata (loc_rddata),
        .loc_ready  (loc_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        w;
        logic        r;
        logic [2:0]  sz;
        logic [63:0] addr;
        logic [63:0] data;
        logic        chk;
        logic [63:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[16];

    task automatic check_val(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_rd(input string name, input logic [63:0] exp);
        check_val(name, loc_rddata, {{(DW-64){1'b0}}, exp});
    endtask

    task automatic check_rdy(input string name, input logic exp);
        check_val(name, {{(DW-1){1'b0}}, loc_ready}, {{(DW-1){1'b0}}, exp});
    endtask

    // Presents one request for a single accepting edge, then returns 1 time unit after it.
    task automatic do_req(input logic w, input logic r, input logic a, input logic [7:0] at,
                          input logic [2:0] sz, input logic [63:0] addr, input logic [63:0] data);
        int n;
        n = 0;
        while (!loc_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!loc_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_timeout: loc_ready stuck at 0, required 1");
        end
        loc_write  = w;
        loc_read   = r;
        loc_atomic = a;
        loc_atype  = at;
        loc_size   = sz;
        loc_addr   = addr;
        loc_wrdata = {{(DW-64){1'b1}}, data};
        @(posedge clk);
        #1;
        loc_write  = 1'b0;
        loc_read   = 1'b0;
        loc_atomic = 1'b0;
    endtask

    // Atomic: checks ready drop, waits out WB, checks returned old value.
    task automatic do_atomic(input string name, input logic [7:0] at, input logic [2:0] sz,
                             input logic [63:0] addr, input logic [63:0] opnd, input logic [63:0] old);
        do_req(1'b0, 1'b0, 1'b1, at, sz, addr, opnd);
        check_rdy({name, "_ready"}, !ATOMIC_EN);
        if (ATOMIC_EN) begin
            @(posedge clk);
            #1;
        end
        check_rd({name, "_old"}, old);
    endtask

    task automatic do_read(input string name, input logic [2:0] sz, input logic [63:0] addr,
                           input logic [63:0] exp);
        do_req(1'b0, 1'b1, 1'b0, 8'h00, sz, addr, 64'h0);
        check_rd(name, exp);
    endtask

    task automatic do_write(input logic [2:0] sz, input logic [63:0] addr, input logic [63:0] data);
        do_req(1'b1, 1'b0, 1'b0, 8'h00, sz, addr, data);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 3'd3, 64'h10,  64'h1122334455667788, 1'b0, 64'h0, "w_full"};
        vecs[1]  = '{1'b0, 1'b1, 3'd3, 64'h10,  64'h0, 1'b1, 64'h1122334455667788, "r_full"};
        vecs[2]  = '{1'b1, 1'b0, 3'd0, 64'h13,  64'hAB, 1'b0, 64'h0, "w_byte"};
        vecs[3]  = '{1'b0, 1'b1, 3'd3, 64'h10,  64'h0, 1'b1, 64'h11223344AB667788, "r_after_byte"};
        vecs[4]  = '{1'b0, 1'b1, 3'd1, 64'h13,  64'h0, 1'b1, 64'h000000000000AB66, "r_half_align"};
        vecs[5]  = '{1'b1, 1'b0, 3'd3, 64'h20,  64'h0, 1'b0, 64'h0, "w_clear"};
        vecs[6]  = '{1'b1, 1'b0, 3'd2, 64'h24,  64'hCAFEBABE, 1'b0, 64'h0, "w_word_hi"};
        vecs[7]  = '{1'b0, 1'b1, 3'd3, 64'h20,  64'h0, 1'b1, 64'hCAFEBABE00000000, "r_word_hi"};
        vecs[8]  = '{1'b1, 1'b1, 3'd3, 64'h20,  64'h0123456789ABCDEF, 1'b1, 64'hCAFEBABE00000000, "rw_prewrite"};
        vecs[9]  = '{1'b0, 1'b1, 3'd3, 64'h20,  64'h0, 1'b1, 64'h0123456789ABCDEF, "r_after_rw"};
        vecs[10] = '{1'b0, 1'b1, 3'd7, 64'h23,  64'h0, 1'b1, 64'h0123456789ABCDEF, "r_size7"};
        vecs[11] = '{1'b0, 1'b1, 3'd3, 64'h810, 64'h0, 1'b1, 64'h11223344AB667788, "r_alias"};
        vecs[12] = '{1'b0, 1'b1, 3'd0, 64'h27,  64'h0, 1'b1, 64'h01, "r_top_byte"};
        vecs[13] = '{1'b0, 1'b1, 3'd2, 64'h25,  64'h0, 1'b1, 64'h01234567, "r_word_align"};
        vecs[14] = '{1'b1, 1'b0, 3'd1, 64'h16,  64'hFFFF1234, 1'b0, 64'h0, "w_half_trunc"};
        vecs[15] = '{1'b0, 1'b1, 3'd3, 64'h8000000000000010, 64'h0, 1'b1, 64'h12343344AB667788, "r_half_trunc"};

        reset      = 1'b1;
        loc_addr   = '0;
        loc_write  = 1'b0;
        loc_read   = 1'b0;
        loc_atomic = 1'b0;
        loc_atype  = 8'h00;
        loc_size   = 3'd0;
        loc_wrdata = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_rdy("reset_ready", 1'b0);
        check_rd("reset_rddata", 64'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_rdy("ready_after_reset", 1'b1);

        for (int i = 0; i < 16; i++) begin
            do_req(vecs[i].w, vecs[i].r, 1'b0, 8'h00, vecs[i].sz, vecs[i].addr, vecs[i].data);
            if (vecs[i].chk) check_rd(vecs[i].name, vecs[i].exp);
        end

        // Signed/unsigned atomics on a 32-bit operand at address 0.
        do_write(3'd3, 64'h0, 64'h0);
        do_write(3'd2, 64'h0, 64'h7FFFFFFF);
        do_atomic("add_ovf", 8'h00, 3'd2, 64'h0, 64'h1, 64'h7FFFFFFF);
        check_rdy("ready_after_wb", 1'b1);
        do_read("add_ovf_mem", 3'd2, 64'h0, ATOMIC_EN ? 64'h80000000 : 64'h7FFFFFFF);
        if (ATOMIC_EN) begin
            do_atomic("maxu", 8'h06, 3'd2, 64'h0, 64'h5, 64'h80000000);
            do_read("maxu_mem", 3'd2, 64'h0, 64'h80000000);
            do_atomic("max", 8'h04, 3'd2, 64'h0, 64'h5, 64'h80000000);
            do_read("max_mem", 3'd2, 64'h0, 64'h5);
            do_atomic("min", 8'h05, 3'd2, 64'h0, 64'hFFFFFFFF, 64'h5);
            do_read("min_mem", 3'd2, 64'h0, 64'hFFFFFFFF);
            do_atomic("minu", 8'h07, 3'd2, 64'h0, 64'h3, 64'hFFFFFFFF);
            do_read("minu_mem", 3'd2, 64'h0, 64'h3);
        end

        // Sub-word atomics must leave neighbouring bytes alone.
        do_write(3'd3, 64'h30, 64'hA5A5A5A5A5A5A5A5);
        do_write(3'd1, 64'h32, 64'hBEEF);
        do_atomic("swap", 8'h08, 3'd1, 64'h32, 64'hDEAD, 64'hBEEF);
        do_read("swap_mem", 3'd1, 64'h32, ATOMIC_EN ? 64'hDEAD : 64'hBEEF);
        if (ATOMIC_EN) begin
            do_atomic("bad_atype", 8'h3F, 3'd1, 64'h32, 64'h1111, 64'hDEAD);
            do_read("bad_atype_mem", 3'd1, 64'h32, 64'hDEAD);
            do_atomic("xor_byte", 8'h03, 3'd0, 64'h31, 64'hFF, 64'hA5);
            do_atomic("add_wrap", 8'h00, 3'd0, 64'h37, 64'h5C, 64'hA5);
            do_read("byte_ops_mem", 3'd3, 64'h30, 64'h01A5A5A5DEAD5AA5);
        end

        // Reset landing on the write-back edge.
        do_write(3'd3, 64'h40, 64'h10);
        do_req(1'b0, 1'b0, 1'b1, 8'h00, 3'd3, 64'h40, 64'h1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_rdy("wb_reset_ready", 1'b0);
        check_rd("wb_reset_rddata", 64'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_rdy("wb_reset_ready_back", 1'b1);
        do_read("wb_reset_mem", 3'd3, 64'h40, 64'h10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

endmodule

// File: doc/umi_loc_mem.md
# umi_loc_mem

Byte-addressable local memory that sits directly downstream of `umi_endpoint` and consumes its `loc_*` request interface. It services plain reads and writes and UMI atomic read-modify-write operations against a 64-bit-wide internal array. It returns read data on `loc_rddata` for the endpoint to pack into UMI responses. It replaces ad-hoc behavioural memories in endpoint benches and serves as the standard scratchpad behind an endpoint.

## Interface
- `DW`, 256: width of `loc_wrdata` and `loc_rddata`; only bits [63:0] are used; upper bits of `loc_rddata` are driven 0.
- `AW`, 64: width of `loc_addr`.
- `DEPTH`, 256: number of 64-bit words; must be a power of two ≥ 2.
- `clk`  input  1  clock; all logic on the rising edge.
- `reset`  input  1  synchronous reset, active-high.
- `loc_addr`  input  AW  byte address; word index = `loc_addr[3+:$clog2(DEPTH)]`, byte lane = `loc_addr[2:0]`; higher bits ignored (aliasing).
- `loc_write`  input  1  write request.
- `loc_read`  input  1  read request.
- `loc_atomic`  input  1  atomic request; implies read plus conditional write.
- `loc_atype`  input  8  atomic operation code.
- `loc_size`  input  3  operand size, 2^size bytes; sizes 4–7 are treated as 3.
- `loc_wrdata`  input  DW  write or atomic operand, right-aligned (operand in bits [8·2^size−1:0]).
- `loc_rddata`  output  DW  read data, right-aligned; registered.
- `loc_ready`  output  1  request accepted on any edge where `loc_ready`=1 and a request is asserted.

## Operation
- Alignment: the byte lane is forced to natural alignment by clearing the low `size` bits of `loc_addr[2:0]`. Operands never cross a word.
- Write: bytes [lane, lane+2^size) of the word are updated from the operand; other bytes are unchanged.
- Read: the selected bytes are shifted down to bit 0 and zero-extended into `loc_rddata`.
- Read and write in the same request: the write is performed and `loc_rddata` returns the pre-write value.
- `loc_atomic` takes precedence; `loc_read` and `loc_write` are ignored when `loc_atomic`=1.
- Atomic ops, at operand width:
  - 0x00 ADD, with wrap-around.
  - 0x01 AND, 0x02 OR, 0x03 XOR.
  - 0x04 MAX and 0x05 MIN, signed compare with the sign taken at operand width.
  - 0x06 MAXU and 0x07 MINU, unsigned compare.
  - 0x08 SWAP.
  - Any other code performs no write and returns the old value.
- Atomic result: `loc_rddata` always returns the old value.
- FSM states:
  - IDLE: `loc_ready`=1. An accepted atomic latches the address, lane, size, atype, operand and old word, then moves to WB.
  - WB: `loc_ready`=0. Writes the ALU result and returns to IDLE unconditionally.
- Memory contents are not reset.

## Timing
- Reset values: `loc_ready`=0 while `reset`=1, then 1 from the first edge after `reset` deasserts. `loc_rddata`=0. State = IDLE.
- Read latency: `loc_rddata` is valid on the edge after acceptance and holds until the next accepted read or atomic.
- Write latency: a write accepted at edge N is visible to a read accepted at edge N+1.
- Atomic: accepted at edge N; old value on `loc_rddata` after edge N+1; result written at edge N+1; next request accepted at edge N+2. Throughput is one atomic per 2 cycles; reads and writes run one per cycle.
- Back-to-back read at N+1 after a write at N to the same word returns the new data.
- Reset asserted in WB abandons the pending atomic write; the memory keeps the old value.

## Configuration
- `UMI_LOC_MEM_ATOMIC_EN`
  - Defined: atomic support as above.
  - Undefined: no FSM and no ALU; `loc_ready`=1 whenever not in reset; `loc_atomic` requests are handled as plain reads with no write.

## Structure
- Package `umi_loc_mem_pkg`: atype constants (`UMI_ATYPE_ADD` … `UMI_ATYPE_SWAP`), FSM state enum (IDLE, WB), and a size-to-byte-mask function.
- Sub-module `umi_loc_atomic_alu`: combinational; takes (atype, size, old, operand) and produces the new value.

## Test plan
- Write size=3, addr 0x10, data 0x1122334455667788; read size=3, addr 0x10 -> `loc_rddata`=0x1122334455667788 one cycle later.
- Write size=0, addr 0x13, data 0xAB over that word; read size=3, addr 0x10 -> 0x11223344AB667788. Read size=1, addr 0x13 (aligned to 0x12) -> 0x0000AB66.
- Word = 0x7FFFFFFF at addr 0 (size=2); atomic ADD operand 1 -> `loc_rddata`=0x7FFFFFFF, `loc_ready` low one cycle, read returns 0x80000000. Then atomic MAX operand 5 -> memory remains 0x80000000? No: signed compare, 5 > −2^31 -> 5. MAXU operand 5 instead -> unchanged.
- Atomic SWAP operand 0xDEAD on a size=1 word holding 0xBEEF -> `loc_rddata`=0xBEEF, then read -> 0xDEAD. Atype 0x3F -> no change.
- Assert `reset` during WB of an atomic ADD -> memory unchanged, `loc_ready`=0 during reset, `loc_rddata`=0 after reset.
- Build without `UMI_LOC_MEM_ATOMIC_EN`: atomic ADD -> `loc_ready` stays 1, old value returned, memory unchanged.
